// File: rtl/bram_zynq_rd_return.sv
// Read-return side of the PS/accelerator BRAM port mux: owns the mux select, tags each
// read with its owner at issue, and steers the BRAM response back to that owner.
//
// state  | meaning
// OWN    | select stable, masters may issue reads
// DRAIN  | owner change requested, waiting for in-flight reads to return
// SWITCH | pipeline empty, select toggles on the exit edge
module bram_zynq_rd_return #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel_req,
  output logic                  sel,
  output logic                  sel_busy,
  input  logic                  bram_en_out,
  input  logic                  bram_we_out,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic                  rd_valid_0,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic                  rd_valid_1,
  output logic [2:0]            inflight
);

  typedef enum logic [1:0] {ST_OWN, ST_DRAIN, ST_SWITCH} state_t;

  state_t                  state_q;
  logic                    sel_q;
  logic                    busy_q;
  logic [RD_LATENCY-1:0]   vld_q;
  logic [RD_LATENCY-1:0]   own_q;
  logic [2:0]              inflight_q;
  logic [2:0]              inflight_d;
  logic [DATA_WIDTH-1:0]   data0_q;
  logic [DATA_WIDTH-1:0]   data1_q;
  logic                    valid0_q;
  logic                    valid1_q;
  logic                    rd_issue;
  logic                    ret_vld;
  logic                    ret_own;

  assign rd_issue = bram_en_out & ~bram_we_out;
  assign ret_vld  = vld_q[RD_LATENCY-1];
  assign ret_own  = own_q[RD_LATENCY-1];

  always_comb begin
    inflight_d = inflight_q + {2'b00, rd_issue} - {2'b00, ret_vld};
  end

  // Tag pipeline: entry i holds a read issued i+1 edges ago; the tail lines up with dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      own_q      <= '0;
      inflight_q <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
      vld_q[0]   <= rd_issue;
      own_q[0]   <= rd_issue & sel_q;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      valid0_q <= ret_vld & ~ret_own;
      valid1_q <= ret_vld & ret_own;
      if (ret_vld && !ret_own) data0_q <= bram_dout;
      if (ret_vld && ret_own)  data1_q <= bram_dout;
    end
  end

  // Uses the registered count, so a read returning this edge still holds off the switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OWN;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_OWN: begin
          if (sel_req != sel_q) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (sel_req == sel_q) begin
            state_q <= ST_OWN;
            busy_q  <= 1'b0;
          end else if (inflight_q == 3'd0 && !rd_issue) begin
            state_q <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          sel_q   <= ~sel_q;
          state_q <= ST_OWN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_OWN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign sel_busy   = busy_q;
  assign rd_data_0  = data0_q;
  assign rd_data_1  = data1_q;
  assign rd_valid_0 = valid0_q;
  assign rd_valid_1 = valid1_q;
  assign inflight   = inflight_q;

endmodule
